// File: rtl/gcu_pkg.sv
// Shared definitions for the graphics control unit: instruction field layout
// and sequencer state encoding.
package gcu_pkg;

  localparam int unsigned X_MSB      = 31;
  localparam int unsigned X_LSB      = 22;
  localparam int unsigned Y_MSB      = 21;
  localparam int unsigned Y_LSB      = 13;
  localparam int unsigned SEL_MSB    = 12;
  localparam int unsigned SEL_LSB    = 10;
  localparam int unsigned SCALE2_BIT = 9;
  localparam int unsigned FLIP_H_BIT = 8;

  localparam logic [2:0] INVISIBLE_SEL = 3'b111;

  typedef enum logic {
    IDLE = 1'b0,
    DRAW = 1'b1
  } state_e;

endpackage

// File: rtl/ins_fifo.sv
// Synchronous instruction FIFO with synchronous active-high reset.
// DEPTH must be a power of two so the pointers wrap naturally.
module ins_fifo #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [AW:0]      count_q;
  logic             do_push;
  logic             do_pop;

  assign full    = (count_q == (AW+1)'(DEPTH));
  assign empty   = (count_q == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign head    = mem_q[rd_ptr_q];

  // Storage array; contents need no reset because count gates visibility.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= wdata;
    end
  end

  // Pointer and occupancy bookkeeping; simultaneous push/pop leaves count unchanged.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/sprite_raster_sequencer.sv
// Sprite raster sequencer: queues draw instructions and walks each sprite as
// a sprite-pixel / screen-pixel coordinate stream, one pixel per BLANK-high
// clock, with 2x scaling, horizontal flip and screen clipping.
module sprite_raster_sequencer
  import gcu_pkg::*;
#(
  parameter int unsigned SPR_W      = 32,
  parameter int unsigned SPR_H      = 32,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned SCR_W      = 640,
  parameter int unsigned SCR_H      = 480
) (
  input  logic                     HF_CLK,
  input  logic                     RST,
  input  logic                     BLANK,
  input  logic [31:0]              INS,
  input  logic                     INS_VALID,
  output logic                     INS_READY,
  output logic [31:0]              CURRENT_INS,
  output logic [$clog2(SPR_W)-1:0] SID_CLM,
  output logic [$clog2(SPR_H)-1:0] SID_ROW,
  output logic [9:0]               PGA_CLM,
  output logic [9:0]               PGA_ROW,
  output logic                     PIX_VALID,
  output logic                     BUSY,
  output logic                     DONE,
  output logic                     SKIP
);

  localparam int unsigned CW  = $clog2(SPR_W);
  localparam int unsigned RW  = $clog2(SPR_H);
  // Offset counters need one extra bit to span the 2x-scaled extent.
  localparam int unsigned OXW = CW + 1;
  localparam int unsigned OYW = RW + 1;

  localparam logic [OXW-1:0] EW1_M1  = OXW'(SPR_W - 1);
  localparam logic [OXW-1:0] EW2_M1  = OXW'(2 * SPR_W - 1);
  localparam logic [OYW-1:0] EH1_M1  = OYW'(SPR_H - 1);
  localparam logic [OYW-1:0] EH2_M1  = OYW'(2 * SPR_H - 1);
  localparam logic [10:0]    SCR_W11 = 11'(SCR_W);
  localparam logic [10:0]    SCR_H11 = 11'(SCR_H);

  state_e         state_q, state_d;
  logic [OXW-1:0] ox_q, ox_d;
  logic [OYW-1:0] oy_q, oy_d;
  logic [31:0]    cur_ins_q, cur_ins_d;
  logic           skip_q, skip_d;

  logic        fifo_push;
  logic        fifo_pop;
  logic [31:0] fifo_head;
  logic        fifo_full;
  logic        fifo_empty;

  logic [9:0]     ins_x;
  logic [8:0]     ins_y;
  logic           ins_scale;
  logic           ins_flip;
  logic [OXW-1:0] ew_m1;
  logic [OYW-1:0] eh_m1;
  logic [CW-1:0]  spr_col;
  logic [RW-1:0]  spr_row;
  logic [10:0]    sum_clm;
  logic [10:0]    sum_row;

  assign INS_READY = ~fifo_full & ~RST;
  assign fifo_push = INS_VALID & INS_READY;

  ins_fifo #(
    .WIDTH (32),
    .DEPTH (FIFO_DEPTH)
  ) u_ins_fifo (
    .clk   (HF_CLK),
    .rst   (RST),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .wdata (INS),
    .head  (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign ins_x     = cur_ins_q[X_MSB:X_LSB];
  assign ins_y     = cur_ins_q[Y_MSB:Y_LSB];
  assign ins_scale = cur_ins_q[SCALE2_BIT];
  assign ins_flip  = cur_ins_q[FLIP_H_BIT];

  assign ew_m1   = ins_scale ? EW2_M1 : EW1_M1;
  assign eh_m1   = ins_scale ? EH2_M1 : EH1_M1;
  assign spr_col = ins_scale ? ox_q[CW:1] : ox_q[CW-1:0];
  assign spr_row = ins_scale ? oy_q[RW:1] : oy_q[RW-1:0];
  // 11-bit sums so a wrap past 1023 still reads as off-screen.
  assign sum_clm = {1'b0, ins_x} + 11'(ox_q);
  assign sum_row = {2'b0, ins_y} + 11'(oy_q);

  assign BUSY        = (state_q == DRAW) | ~fifo_empty;
  assign SKIP        = skip_q;
  assign CURRENT_INS = cur_ins_q;

  // Next-state, pop control and combinational pixel outputs.
  always_comb begin
    state_d   = state_q;
    ox_d      = ox_q;
    oy_d      = oy_q;
    cur_ins_d = cur_ins_q;
    skip_d    = 1'b0;
    fifo_pop  = 1'b0;
    SID_CLM   = '0;
    SID_ROW   = '0;
    PGA_CLM   = '0;
    PGA_ROW   = '0;
    PIX_VALID = 1'b0;
    DONE      = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (BLANK && !fifo_empty && !RST) begin
          fifo_pop = 1'b1;
          if (fifo_head[SEL_MSB:SEL_LSB] == INVISIBLE_SEL) begin
            skip_d = 1'b1;
          end else begin
            cur_ins_d = fifo_head;
            ox_d      = '0;
            oy_d      = '0;
            state_d   = DRAW;
          end
        end
      end
      DRAW: begin
        SID_CLM   = ins_flip ? ~spr_col : spr_col;
        SID_ROW   = spr_row;
        PGA_CLM   = sum_clm[9:0];
        PGA_ROW   = sum_row[9:0];
        PIX_VALID = BLANK & (sum_clm < SCR_W11) & (sum_row < SCR_H11);
        if (BLANK) begin
          if (ox_q == ew_m1) begin
            ox_d = '0;
            if (oy_q == eh_m1) begin
              oy_d    = '0;
              DONE    = 1'b1;
              state_d = IDLE;
            end else begin
              oy_d = oy_q + 1'b1;
            end
          end else begin
            ox_d = ox_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Sequencer state register; reset aborts any sprite in flight.
  always_ff @(posedge HF_CLK) begin
    if (RST) begin
      state_q   <= IDLE;
      ox_q      <= '0;
      oy_q      <= '0;
      cur_ins_q <= '0;
      skip_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      ox_q      <= ox_d;
      oy_q      <= oy_d;
      cur_ins_q <= cur_ins_d;
      skip_q    <= skip_d;
    end
  end

endmodule

// File: doc/sprite_raster_sequencer.md
Name: sprite_raster_sequencer

Overview:
- Parametrised successor to the single-instruction sprite scanner in the graphics path.
- Accepts 32-bit draw instructions through a valid/ready port into an internal FIFO.
- Rasterises each instruction's sprite as a sprite-pixel coordinate stream plus a screen (PGA) coordinate stream, one pixel per active clock.
- Adds configurable sprite size, 2x scaling, horizontal flip, screen clipping, BLANK stalling and skip/done reporting. Sits between the instruction source and the sprite ROM / frame-buffer write logic.

Parameters:
- SPR_W, 32, sprite width in pixels (power of two, 2..64).
- SPR_H, 32, sprite height in pixels (power of two, 2..64).
- FIFO_DEPTH, 4, instruction FIFO entries (power of two, >=2).
- SCR_W, 640, visible screen width; columns >= SCR_W are clipped.
- SCR_H, 480, visible screen height; rows >= SCR_H are clipped.

Ports:
- HF_CLK, in, 1: single clock, all logic on the rising edge.
- RST, in, 1: synchronous, active-high reset.
- BLANK, in, 1: 1 = drawing permitted; 0 = stall (state and counters hold).
- INS, in, 32: instruction. [31:22] X, [21:13] Y, [12:10] SEL (3'b111 = invisible), [9] SCALE2, [8] FLIP_H, [7:0] reserved.
- INS_VALID, in, 1: INS is valid.
- INS_READY, out, 1: FIFO not full and RST low.
- CURRENT_INS, out, 32: instruction being drawn.
- SID_CLM, out, $clog2(SPR_W): sprite-pixel column.
- SID_ROW, out, $clog2(SPR_H): sprite-pixel row.
- PGA_CLM, out, 10: screen column.
- PGA_ROW, out, 10: screen row.
- PIX_VALID, out, 1: coordinates form an on-screen pixel to write.
- BUSY, out, 1: state is DRAW or FIFO non-empty.
- DONE, out, 1: one-cycle pulse on the final pixel cycle of a drawn instruction.
- SKIP, out, 1: one-cycle pulse when an invisible instruction is discarded.

Behaviour:
- Reset (RST=1 at an edge): FIFO empty, state IDLE, counters 0, CURRENT_INS=0. All outputs 0, including INS_READY. Reset wins over every other event, including mid-DRAW; the aborted instruction is lost and emits no DONE.
- Push: INS_VALID & INS_READY at an edge writes INS to the FIFO tail. INS_READY = !full & !RST.
- IDLE: when BLANK=1 and the FIFO is non-empty, pop the head at the edge.
  - SEL=3'b111: pulse SKIP next cycle, stay IDLE. This pop consumes one cycle.
  - Otherwise: CURRENT_INS <= head, screen offset counters OX=OY=0, next state DRAW.
- IDLE with BLANK=0 or an empty FIFO: hold.
- DRAW, pixel cycle:
  - Effective size EW=SPR_W<<SCALE2, EH=SPR_H<<SCALE2.
  - Counters run OX = 0..EW-1 (inner) and OY = 0..EH-1 (outer).
  - BLANK=0 freezes OX/OY with PIX_VALID=0; the cycle is not counted.
- Coordinate mapping:
  - sc = OX>>SCALE2; sr = OY>>SCALE2.
  - SID_CLM = FLIP_H ? SPR_W-1-sc : sc; SID_ROW = sr.
  - PGA_CLM = X+OX, PGA_ROW = Y+OY, computed at 11 bits. Outputs are the low 10 bits.
- Clipping: PIX_VALID = DRAW & BLANK & (sum11_clm < SCR_W) & (sum11_row < SCR_H). This covers both 10-bit wrap and off-screen pixels. Clipped pixels still consume their cycle, so timing is independent of position.
- Completion: on the cycle with OX=EW-1, OY=EH-1 and BLANK=1, DONE=1. Next state is IDLE. The next instruction may pop on the following cycle, giving exactly one bubble between sprites.
- Latency: a push accepted at edge N lets the FIFO present the head in cycle N+1 and pop at the end of it. The first PIX_VALID appears in cycle N+2. A drawn instruction occupies EW*EH BLANK-high cycles.
- Outputs SID/PGA/PIX_VALID/DONE are combinational from registered state and counters. In IDLE they read 0. CURRENT_INS holds its last value in IDLE.
- Full FIFO: INS_READY=0 and INS_VALID is ignored. A push and a pop in the same edge are both honoured, and the count is unchanged.

Decomposition:
- Package gcu_pkg:
  - instruction field offsets (X_MSB/LSB, Y_MSB/LSB, SEL, SCALE2, FLIP_H);
  - constant INVISIBLE_SEL = 3'b111;
  - state enum {IDLE, DRAW}.
- One sub-module, ins_fifo: parametrised synchronous FIFO (WIDTH, DEPTH; push, pop, head, full, empty, sync active-high reset). The sequencer FSM and counters live in the top.

Test Plan:
- SPR_W=SPR_H=4, push X=100,Y=50, SEL=0 with BLANK=1 → PIX_VALID for 16 consecutive cycles starting 2 cycles after the push. (SID_CLM,SID_ROW) go (0,0)..(3,3) row-major; PGA goes (100,50)..(103,53); DONE on the 16th cycle only.
- Push an invisible instruction (SEL=7) followed by a visible one → SKIP pulses once with no PIX_VALID for the first. The second instruction draws normally, starting one cycle later.
- SCALE2=1, FLIP_H=1, SPR 4x4 at (0,0) → 64 pixel cycles. PGA_CLM runs 0..7, and SID_CLM runs 3,3,2,2,1,1,0,0 across each row.
- X=638, SPR 4x4 → columns 638 and 639 give PIX_VALID=1; columns 640 and 641 give PIX_VALID=0. Total cycles remain 16. With X=1022, wrapped columns 0 and 1 are also clipped.
- Deassert BLANK for 5 cycles mid-sprite → counters and outputs freeze with PIX_VALID=0, then resume at the same pixel. The total pixel count is unchanged.
- Fill the FIFO with 4 instructions → INS_READY=0 and a 5th push is refused. Assert RST mid-DRAW → next cycle FIFO empty, IDLE, all outputs 0, no DONE.
